car_detector: RTL and testbench

//  Front-end for the country-road loop sensor; sits directly upstream of trafficlight and drives its car input.

---
 rtl/trafficlight_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/car_detector.sv | 126 ++++++++++++
 tb/tb_car_detector.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/trafficlight_pkg.sv
// trafficlight_pkg: shared types and light-index constants for the traffic light and its car detector
package trafficlight_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUALIFY,
        PRESENT,
        CLEAR
    } det_state_t;

    localparam int LIGHT_CR_G = 5;
    localparam int LIGHT_CR_Y = 4;
    localparam int LIGHT_CR_R = 3;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input
//   clk   in  system clock
//   rst_n in  asynchronous reset, active low (both flops clear to 0)
//   d     in  asynchronous input
//   q     out synchronised copy of d, two edges of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/car_detector.sv
// car_detector: synchronises and debounces the country-road loop sensor and keeps a saturating queue count drained on green
//   clk        in  system clock
//   rst_n      in  asynchronous reset, active low
//   sensor_raw in  raw loop sensor, asynchronous, may bounce
//   cr_green   in  country-road green (trafficlight light[LIGHT_CR_G])
//   car        out vehicle waiting, equals car_count != 0
//   car_count  out vehicles queued, saturating
//   arrival    out one-cycle pulse per accepted arrival
//   overflow   out sticky flag, an arrival was dropped at saturation
module car_detector
    import trafficlight_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 4,
    parameter int PASS_CYC     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_raw,
    input  logic             cr_green,
    output logic             car,
    output logic [CNT_W-1:0] car_count,
    output logic             arrival,
    output logic             overflow
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int PW = $clog2(PASS_CYC + 1);
    localparam logic [DW-1:0]    DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [PW-1:0]    PASS_LAST = PW'(PASS_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             s_sync;
    det_state_t       state, state_nxt;
    logic [DW-1:0]    deb_cnt, deb_nxt;
    logic             arr_evt;
    logic [PW-1:0]    pass_cnt;
    logic             busy, dec, sat;
    logic [CNT_W-1:0] cnt_nxt;

    sync_2ff u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sensor_raw),
        .q    (s_sync)
    );

    // Debounce: DEBOUNCE_CYC consecutive matching samples accept a transition;
    // the terminal-count test uses DEB_LAST because the current edge is the last one.
    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        arr_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (s_sync) begin
                    state_nxt = QUALIFY;
                    deb_nxt   = DW'(1);
                end
            end
            QUALIFY: begin
                if (!s_sync) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = PRESENT;
                    deb_nxt   = '0;
                    arr_evt   = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            PRESENT: begin
                if (!s_sync) begin
                    state_nxt = CLEAR;
                    deb_nxt   = DW'(1);
                end
            end
            CLEAR: begin
                if (s_sync) begin
                    state_nxt = PRESENT;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                deb_nxt   = '0;
            end
        endcase
    end

    // Arrival and service on the same edge cancel; an arrival at saturation is dropped and flagged.
    always_comb begin
        busy    = car_count != '0;
        dec     = cr_green && busy && pass_cnt == PASS_LAST;
        sat     = car_count == CNT_MAX;
        cnt_nxt = (arr_evt && !dec && !sat) ? car_count + CNT_W'(1) :
                  (dec && !arr_evt)         ? car_count - CNT_W'(1) : car_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            pass_cnt  <= '0;
            car_count <= '0;
            car       <= 1'b0;
            arrival   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            deb_cnt   <= deb_nxt;
            pass_cnt  <= (!cr_green || !busy || dec) ? '0 : pass_cnt + PW'(1);
            car_count <= cnt_nxt;
            car       <= cnt_nxt != '0;
            arrival   <= arr_evt;
            overflow  <= overflow | (arr_evt & !dec & sat);
        end
    end

endmodule

// File: tb/tb_car_detector.sv
// tb_car_detector: scoreboard bench; CNT_W=2 so the saturation case fits alongside the default-timing cases
module tb_car_detector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor_raw = 1'b0;
    logic       cr_green = 1'b0;
    logic       car;
    logic [1:0] car_count;
    logic       arrival;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic       arr;
        logic [1:0] cnt;
        logic       car;
        logic       ovf;
        int         at;
    } ev_t;

    ev_t q[$];

    car_detector #(.DEBOUNCE_CYC(4), .CNT_W(2), .PASS_CYC(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensor_raw(sensor_raw),
        .cr_green  (cr_green),
        .car       (car),
        .car_count (car_count),
        .arrival   (arrival),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any arrival pulse or change of count/overflow is a DUT event to be matched in order.
    logic [1:0] p_cnt = '0;
    logic       p_ovf = 1'b0;
    always @(negedge clk) begin
        if (arrival || car_count != p_cnt || overflow != p_ovf) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d arrival=%0b count=%0d car=%0b ovf=%0b", cyc, arrival, car_count, car, overflow);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (arrival !== e.arr || car_count !== e.cnt || car !== e.car || overflow !== e.ovf || (e.at != 0 && cyc != e.at)) begin
                    failures++;
                    $display("FAIL event cyc=%0d arrival=%0b count=%0d car=%0b ovf=%0b expected cyc=%0d arrival=%0b count=%0d car=%0b ovf=%0b",
                             cyc, arrival, car_count, car, overflow, e.at, e.arr, e.cnt, e.car, e.ovf);
                end
            end
        end
        p_cnt <= car_count;
        p_ovf <= overflow;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input logic a, input logic [1:0] c, input logic o, input int at);
        ev_t e;
        e.arr = a;
        e.cnt = c;
        e.car = c != 2'd0;
        e.ovf = o;
        e.at  = at;
        q.push_back(e);
    endtask

    // Clean pulse: arrival lands on the 6th edge after the raw step.
    task automatic arrive(input logic [1:0] c, input logic o);
        sensor_raw = 1'b1;
        push(1'b1, c, o, cyc + 6);
        step(8);
        sensor_raw = 1'b0;
        step(8);
    endtask

    int g;

    initial begin
        #1;
        chk("reset_car", car, 0);
        chk("reset_count", car_count, 0);
        chk("reset_arrival", arrival, 0);
        chk("reset_overflow", overflow, 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // clean step held 20 cycles, single arrival
        sensor_raw = 1'b1;
        push(1'b1, 2'd1, 1'b0, cyc + 6);
        step(20);
        sensor_raw = 1'b0;
        step(10);
        chk("clean_count", car_count, 1);
        chk("clean_car", car, 1);

        // bounce: never qualifies
        for (int i = 0; i < 10; i++) begin
            sensor_raw = (i % 2 == 0);
            step(1);
        end
        sensor_raw = 1'b0;
        step(10);
        chk("bounce_count", car_count, 1);

        // drain three with a mid-interval green drop
        arrive(2'd2, 1'b0);
        arrive(2'd3, 1'b0);
        g = cyc;
        cr_green = 1'b1;
        step(4);
        cr_green = 1'b0;
        step(2);
        cr_green = 1'b1;
        push(1'b0, 2'd2, 1'b0, g + 14);
        push(1'b0, 2'd1, 1'b0, g + 22);
        push(1'b0, 2'd0, 1'b0, g + 30);
        step(34);
        cr_green = 1'b0;
        chk("drain_car", car, 0);

        // arrival coinciding with a decrement
        arrive(2'd1, 1'b0);
        g = cyc;
        cr_green = 1'b1;
        step(2);
        sensor_raw = 1'b1;
        push(1'b1, 2'd1, 1'b0, g + 8);
        push(1'b0, 2'd0, 1'b0, g + 16);
        step(8);
        sensor_raw = 1'b0;
        step(12);
        cr_green = 1'b0;
        chk("simul_count", car_count, 0);

        // saturation at 3, sticky overflow
        arrive(2'd1, 1'b0);
        arrive(2'd2, 1'b0);
        arrive(2'd3, 1'b0);
        arrive(2'd3, 1'b1);
        chk("sat_count", car_count, 3);
        chk("sat_overflow", overflow, 1);
        g = cyc;
        cr_green = 1'b1;
        push(1'b0, 2'd2, 1'b1, g + 8);
        push(1'b0, 2'd1, 1'b1, g + 16);
        push(1'b0, 2'd0, 1'b1, g + 24);
        step(28);
        cr_green = 1'b0;
        chk("sat_overflow_after_drain", overflow, 1);

        // async reset while qualifying with count 2
        arrive(2'd1, 1'b1);
        arrive(2'd2, 1'b1);
        sensor_raw = 1'b1;
        step(4);
        push(1'b0, 2'd0, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_car", car, 0);
        chk("mid_reset_count", car_count, 0);
        chk("mid_reset_arrival", arrival, 0);
        chk("mid_reset_overflow", overflow, 0);
        sensor_raw = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        arrive(2'd1, 1'b0);
        chk("post_reset_count", car_count, 1);

        step(5);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
